// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT output serializer.
// Sign-magnitude output is enabled by defining FFT_SER_SIGNMAG_EN.
package fft_pkg;

    localparam int NPT  = 16;
    localparam int DW   = 16;
    localparam int IDXW = 4;

    typedef struct packed {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
    } cplx_t;

    // Two's complement to sign-magnitude; the most negative value saturates.
    function automatic logic [DW-1:0] to_signmag(input logic [DW-1:0] v);
        logic [DW-1:0] mag;
        logic [DW-1:0] r;
        mag = -v;
        if (!v[DW-1]) begin
            r = v;
        end else if (v == {1'b1, {(DW-1){1'b0}}}) begin
            r = '1;
        end else begin
            r = {1'b1, mag[DW-2:0]};
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_out_serializer_bank.sv
// One frame bank: all bins written in one cycle, one bin read by index.
// Contents are not reset; reads are only meaningful while the bank is full.
module fft_frame_bank
    import fft_pkg::*;
(
    input  logic              clk,
    input  logic              we_i,
    input  logic [NPT*DW-1:0] re_i,
    input  logic [NPT*DW-1:0] im_i,
    input  logic [IDXW-1:0]   idx_i,
    output cplx_t             rd_o
);

    cplx_t mem_q [NPT];

    // Capture a whole frame when write-enabled
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int k = 0; k < NPT; k++) begin
                mem_q[k].re <= re_i[k*DW +: DW];
                mem_q[k].im <= im_i[k*DW +: DW];
            end
        end
    end

    assign rd_o = mem_q[idx_i];

endmodule

// File: rtl/fft_out_serializer.sv
// Double-banked frame capture, streamed out one bin per beat.
// Define FFT_SER_SIGNMAG_EN for sign-magnitude beat components.
module fft_out_serializer #(
    parameter int NPT = 16,
    parameter int DW  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_valid,
    input  logic [NPT*DW-1:0] in_re,
    input  logic [NPT*DW-1:0] in_im,
    output logic              frame_ready,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [3:0]        m_index,
    output logic [DW-1:0]     m_re,
    output logic [DW-1:0]     m_im,
    output logic              m_last,
    output logic              overflow,
    input  logic              clr_ovf
);
    import fft_pkg::*;

    logic       wr_bank_q, wr_bank_d;
    logic       rd_bank_q, rd_bank_d;
    logic [1:0] fill_q, fill_d;
    logic [3:0] rd_idx_q, rd_idx_d;
    logic       ovf_q, ovf_d;

    logic  cap, drop, xfer, rel;
    cplx_t rd0, rd1, beat;
    logic [DW-1:0] beat_re, beat_im;

    assign frame_ready = (fill_q != 2'd2);
    assign m_valid     = (fill_q != 2'd0);
    assign cap         = frame_valid && frame_ready;
    assign drop        = frame_valid && !frame_ready;
    assign xfer        = m_valid && m_ready;
    assign rel         = xfer && (rd_idx_q == 4'hF);

    fft_frame_bank u_bank0 (
        .clk   (clk),
        .we_i  (cap && !wr_bank_q),
        .re_i  (in_re),
        .im_i  (in_im),
        .idx_i (rd_idx_q),
        .rd_o  (rd0)
    );

    fft_frame_bank u_bank1 (
        .clk   (clk),
        .we_i  (cap && wr_bank_q),
        .re_i  (in_re),
        .im_i  (in_im),
        .idx_i (rd_idx_q),
        .rd_o  (rd1)
    );

    // Next-state for bank pointers, occupancy, read index and overflow
    always_comb begin
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        fill_d    = fill_q;
        rd_idx_d  = rd_idx_q;
        ovf_d     = ovf_q;
        if (cap) begin
            wr_bank_d = ~wr_bank_q;
        end
        if (xfer) begin
            rd_idx_d = rd_idx_q + 4'd1;
        end
        if (rel) begin
            rd_bank_d = ~rd_bank_q;
        end
        unique case ({cap, rel})
            2'b10:   fill_d = fill_q + 2'd1;
            2'b01:   fill_d = fill_q - 2'd1;
            default: fill_d = fill_q;
        endcase
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    // Control state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            fill_q    <= 2'd0;
            rd_idx_q  <= 4'd0;
            ovf_q     <= 1'b0;
        end else begin
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            fill_q    <= fill_d;
            rd_idx_q  <= rd_idx_d;
            ovf_q     <= ovf_d;
        end
    end

    assign beat = rd_bank_q ? rd1 : rd0;

`ifdef FFT_SER_SIGNMAG_EN
    assign beat_re = to_signmag(beat.re);
    assign beat_im = to_signmag(beat.im);
`else
    assign beat_re = beat.re;
    assign beat_im = beat.im;
`endif

    assign m_index  = rd_idx_q;
    assign m_last   = m_valid && (rd_idx_q == 4'hF);
    assign m_re     = m_valid ? beat_re : '0;
    assign m_im     = m_valid ? beat_im : '0;
    assign overflow = ovf_q;

endmodule
